// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO registers; E-stage neighbour of the ALU.
// Latency: mthi/mtlo commit on the launch edge; mult-class ops hold busy for
//   MULT_CYCLES and div/divu for DIV_CYCLES, with hi/lo updated as busy drops.
// Backpressure: none internally; the hazard unit stalls on (busy | start), and a
//   start seen while busy is dropped.
// Ports:
//   clk, reset       : clock and synchronous active-high reset
//   start, md_op     : launch request and opcode (0 none, 1 mult, 2 multu, 3 div,
//                      4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu)
//   d1, d2           : forwarded rs / rt operands
//   flush            : squash the in-flight op and any op presented this cycle
//   busy, hi, lo     : in-progress flag and the architectural HI/LO registers
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH-1:0] sh_hi, sh_lo, sh_hi_nxt, sh_lo_nxt;
  logic            sh_commit, sh_commit_nxt;

  // ---------------------------------------------------------------------------
  // Multiply / multiply-accumulate. Both operands are extended to 2*WIDTH so a
  // single unsigned 2W x 2W product (truncated) yields the correct modulo result
  // for signed and unsigned forms alike.
  // ---------------------------------------------------------------------------
  logic                 mul_signed;
  logic [2*WIDTH-1:0]   m1, m2, prod, acc, mul_res;

  always_comb begin
    mul_signed = (md_op == OP_MULT) || (md_op == OP_MADD) || (md_op == OP_MSUB);
    m1   = mul_signed ? {{WIDTH{d1[WIDTH-1]}}, d1} : {{WIDTH{1'b0}}, d1};
    m2   = mul_signed ? {{WIDTH{d2[WIDTH-1]}}, d2} : {{WIDTH{1'b0}}, d2};
    prod = m1 * m2;
    acc  = {hi, lo};
    case (md_op)
      OP_MADD, OP_MADDU: mul_res = acc + prod;
      OP_MSUB, OP_MSUBU: mul_res = acc - prod;
      default:           mul_res = prod;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Divide. Signed division runs on magnitudes and fixes signs afterwards:
  // quotient truncates toward zero, remainder takes the sign of d1. A zero
  // divisor is replaced by 1 only to keep the datapath defined; that result is
  // never committed.
  // ---------------------------------------------------------------------------
  logic             div_signed, div_zero, div_ovf;
  logic [WIDTH-1:0] num, den, den_safe, uq, ur, q, r;

  always_comb begin
    div_signed = (md_op == OP_DIV);
    div_zero   = (d2 == '0);
    div_ovf    = div_signed && (d1 == MOST_NEG) && (d2 == '1);
    num        = (div_signed && d1[WIDTH-1]) ? -d1 : d1;
    den        = (div_signed && d2[WIDTH-1]) ? -d2 : d2;
    den_safe   = div_zero ? WIDTH'(1) : den;
    uq         = num / den_safe;
    ur         = num % den_safe;
    q          = (div_signed && (d1[WIDTH-1] ^ d2[WIDTH-1])) ? -uq : uq;
    r          = (div_signed && d1[WIDTH-1]) ? -ur : ur;
    if (div_ovf) begin
      q = d1;
      r = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      sh_hi     <= '0;
      sh_lo     <= '0;
      sh_commit <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hi        <= hi_nxt;
      lo        <= lo_nxt;
      sh_hi     <= sh_hi_nxt;
      sh_lo     <= sh_lo_nxt;
      sh_commit <= sh_commit_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Control: next state. The result is captured into the shadow registers at
  // launch (so madd/msub see hi/lo as of launch) and copied to hi/lo in one
  // step when the counter reaches zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hi_nxt        = hi;
    lo_nxt        = lo;
    sh_hi_nxt     = sh_hi;
    sh_lo_nxt     = sh_lo;
    sh_commit_nxt = sh_commit;

    case (state)
      S_IDLE: begin
        if (start && !flush) begin
          case (md_op)
            OP_MTHI: hi_nxt = d1;
            OP_MTLO: lo_nxt = d1;
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              sh_hi_nxt     = mul_res[2*WIDTH-1:WIDTH];
              sh_lo_nxt     = mul_res[WIDTH-1:0];
              sh_commit_nxt = 1'b1;
              cnt_nxt       = CW'(MULT_CYCLES);
              state_nxt     = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              sh_hi_nxt     = r;
              sh_lo_nxt     = q;
              sh_commit_nxt = !div_zero;
              cnt_nxt       = CW'(DIV_CYCLES);
              state_nxt     = S_BUSY;
            end
            default: ;  // none / reserved
          endcase
        end
      end

      S_BUSY: begin
        if (flush) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else if (cnt == CW'(1)) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
          if (sh_commit) begin
            hi_nxt = sh_hi;
            lo_nxt = sh_lo;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_BUSY);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] d1;
  logic [31:0] d2;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .d1    (d1),
    .d2    (d2),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: presents an op for one cycle, returns at the negedge
  // after the launch edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    d1    = a;
    d2    = b;
    @(negedge clk);
    start = 1'b0;
    md_op = 4'd0;
  endtask

  // Counts busy-high samples (one per cycle) until busy drops; 'seen' is the
  // number of busy cycles already observed by the caller.
  task automatic wait_done(input string tag, input int exp_n, input int seen);
    int n;
    n = seen;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    md_op = 4'd0;
    d1    = '0;
    d2    = '0;
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // signed mult -3 * 7
    issue(4'd1, 32'hFFFF_FFFD, 32'd7);
    chk("mult_busy_c1", {31'd0, busy}, 32'd1);
    chk("mult_hi_held", hi, 32'd0);
    wait_done("mult_cycles", 5, 0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    // signed div -7 / 2
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_cycles", 10, 0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // signed div 7 / -2
    issue(4'd3, 32'd7, 32'hFFFF_FFFE);
    wait_done("div2_cycles", 10, 0);
    chk("div2_lo", lo, 32'hFFFF_FFFD);
    chk("div2_hi", hi, 32'd1);

    // preset and divide by zero
    issue(4'd5, 32'd5, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'd5);
    issue(4'd6, 32'd6, 32'd0);
    chk("mtlo_lo", lo, 32'd6);
    chk("mtlo_hi_kept", hi, 32'd5);
    issue(4'd4, 32'd9, 32'd0);
    wait_done("divz_cycles", 10, 0);
    chk("divz_hi", hi, 32'd5);
    chk("divz_lo", lo, 32'd6);

    // signed overflow
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("ovf_cycles", 10, 0);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    // maddu carry into hi, then msub borrow back
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    issue(4'd8, 32'd1, 32'd1);
    wait_done("maddu_cycles", 5, 0);
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
    issue(4'd9, 32'd1, 32'd1);
    wait_done("msub_cycles", 5, 0);
    chk("msub_hi", hi, 32'd0);
    chk("msub_lo", lo, 32'hFFFF_FFFF);

    // multu full-range, then signed madd of -2*3
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_cycles", 5, 0);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    issue(4'd7, 32'hFFFF_FFFE, 32'd3);
    wait_done("madd_cycles", 5, 0);
    chk("madd_hi", hi, 32'hFFFF_FFFD);
    chk("madd_lo", lo, 32'hFFFF_FFFB);

    // divu 100 / 7
    issue(4'd4, 32'd100, 32'd7);
    wait_done("divu_cycles", 10, 0);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // reserved and none opcodes do nothing
    issue(4'd12, 32'hDEAD_BEEF, 32'd1);
    chk("rsvd_busy", {31'd0, busy}, 32'd0);
    chk("rsvd_lo", lo, 32'd14);
    chk("rsvd_hi", hi, 32'd2);

    // flush in busy cycle 2
    issue(4'd2, 32'd4, 32'd5);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi, 32'd2);
    chk("flush_lo", lo, 32'd14);
    repeat (6) @(negedge clk);
    chk("flush_late_lo", lo, 32'd14);

    // start + flush together
    flush = 1'b1;
    issue(4'd6, 32'd9, 32'd0);
    flush = 1'b0;
    chk("sflush_lo", lo, 32'd14);
    chk("sflush_busy", {31'd0, busy}, 32'd0);
    flush = 1'b1;
    issue(4'd1, 32'd3, 32'd3);
    flush = 1'b0;
    chk("sflush_mult_busy", {31'd0, busy}, 32'd0);

    // reset in busy cycle 3
    issue(4'd5, 32'h11, 32'd0);
    issue(4'd3, 32'd100, 32'd3);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    repeat (10) @(negedge clk);
    chk("rstmid_late_lo", lo, 32'd0);

    // starts while busy are ignored
    issue(4'd1, 32'd6, 32'd7);
    start = 1'b1;
    md_op = 4'd5;
    d1    = 32'hDEAD;
    @(negedge clk);
    md_op = 4'd3;
    d1    = 32'd100;
    d2    = 32'd0;
    @(negedge clk);
    start = 1'b0;
    md_op = 4'd0;
    chk("ign_hi_mid", hi, 32'd0);
    wait_done("ign_cycles", 5, 2);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
